// File: rtl/ps2_key_decoder.sv
// ps2_key_decoder: turns Set-2 scancode bytes into key events.
// Resolves the E0/F0/E1 prefixes and tracks the shift and caps-lock state.
// Each resolved event is pushed into a first-word-fall-through FIFO, which the
// consumer drains with rd_en.
//
// Handshake: a byte is consumed only in a cycle with code_valid=1. The FIFO
// head is presented whenever key_valid=1. It is popped at a posedge where
// rd_en=1 and key_valid=1. rd_en while key_valid=0 has no effect.
module ps2_key_decoder #(
   parameter int FIFO_DEPTH = 8,
   parameter int ADDR_W     = 3
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] code_in,
   input  logic       code_valid,
   input  logic       rd_en,
   output logic       key_valid,
   output logic [7:0] key_ascii,
   output logic [7:0] key_code,
   output logic       key_break,
   output logic       key_ext,
   output logic       fifo_full,
   output logic       overflow,
   output logic       shift_held,
   output logic       caps_lock,
   output logic [2:0] fsm_state
);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_E0   = 3'd1,
      S_F0   = 3'd2,
      S_E0F0 = 3'd3,
      S_SKIP = 3'd4
   } state_t;

   state_t     state, state_nx;
   logic [2:0] skip_cnt, skip_nx;

   // Resolved event for the current byte (combinational).
   logic       evt_valid;
   logic       evt_brk;
   logic       evt_ext;
   logic       is_shift;
   logic       is_caps;
   logic       is_fake;
   logic       push;
   logic [7:0] evt_ascii;
   logic [17:0] evt_word;

   // Modifier state.
   logic shift_l, shift_r, caps_held;

   // FIFO.
   logic [17:0]     mem [FIFO_DEPTH];
   logic [ADDR_W:0] wptr, rptr;
   logic            empty, full, pop, push_ok;
   logic [17:0]     head;

   // Lowercase letter for a Set-2 code, 0x00 if the code is not a letter.
   function automatic logic [7:0] letter_of(input logic [7:0] c);
      logic [7:0] r;
      r = 8'h00;
      case (c)
         8'h1C: r = 8'h61; 8'h32: r = 8'h62; 8'h21: r = 8'h63; 8'h23: r = 8'h64;
         8'h24: r = 8'h65; 8'h2B: r = 8'h66; 8'h34: r = 8'h67; 8'h33: r = 8'h68;
         8'h43: r = 8'h69; 8'h3B: r = 8'h6A; 8'h42: r = 8'h6B; 8'h4B: r = 8'h6C;
         8'h3A: r = 8'h6D; 8'h31: r = 8'h6E; 8'h44: r = 8'h6F; 8'h4D: r = 8'h70;
         8'h15: r = 8'h71; 8'h2D: r = 8'h72; 8'h1B: r = 8'h73; 8'h2C: r = 8'h74;
         8'h3C: r = 8'h75; 8'h2A: r = 8'h76; 8'h1D: r = 8'h77; 8'h22: r = 8'h78;
         8'h35: r = 8'h79; 8'h1A: r = 8'h7A;
         default: r = 8'h00;
      endcase
      return r;
   endfunction

   // Digit row: plain digit, or the US shifted symbol when shift is held.
   function automatic logic [7:0] digit_of(input logic [7:0] c, input logic sh);
      logic [7:0] r;
      r = 8'h00;
      case (c)
         8'h16: r = sh ? 8'h21 : 8'h31; // ! 1
         8'h1E: r = sh ? 8'h40 : 8'h32; // @ 2
         8'h26: r = sh ? 8'h23 : 8'h33; // # 3
         8'h25: r = sh ? 8'h24 : 8'h34; // $ 4
         8'h2E: r = sh ? 8'h25 : 8'h35; // % 5
         8'h36: r = sh ? 8'h5E : 8'h36; // ^ 6
         8'h3D: r = sh ? 8'h26 : 8'h37; // & 7
         8'h3E: r = sh ? 8'h2A : 8'h38; // * 8
         8'h46: r = sh ? 8'h28 : 8'h39; // ( 9
         8'h45: r = sh ? 8'h29 : 8'h30; // ) 0
         default: r = 8'h00;
      endcase
      return r;
   endfunction

   // Full translation of a non-extended code. It uses the modifiers as they
   // were before this byte.
   function automatic logic [7:0] xlate(input logic [7:0] c, input logic sh,
                                        input logic cl);
      logic [7:0] lt;
      logic [7:0] r;
      lt = letter_of(c);
      r  = 8'h00;
      if (lt != 8'h00) begin
         r = (sh ^ cl) ? (lt - 8'h20) : lt;
      end else begin
         case (c)
            8'h29:   r = 8'h20;
            8'h5A:   r = 8'h0D;
            8'h66:   r = 8'h08;
            8'h0D:   r = 8'h09;
            8'h76:   r = 8'h1B;
            default: r = digit_of(c, sh);
         endcase
      end
      return r;
   endfunction

   // Prefix FSM state register plus pause-sequence skip counter.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= S_IDLE;
         skip_cnt <= 3'd0;
      end else begin
         state    <= state_nx;
         skip_cnt <= skip_nx;
      end
   end

   // Prefix FSM next-state logic.
   always_comb begin
      state_nx = state;
      skip_nx  = skip_cnt;
      if (code_valid) begin
         case (state)
            S_IDLE: begin
               case (code_in)
                  8'hE0:   state_nx = S_E0;
                  8'hF0:   state_nx = S_F0;
                  8'hE1: begin
                     state_nx = S_SKIP;
                     skip_nx  = 3'd7;
                  end
                  default: state_nx = S_IDLE;
               endcase
            end
            S_E0:    state_nx = (code_in == 8'hF0) ? S_E0F0 : S_IDLE;
            S_F0:    state_nx = S_IDLE;
            S_E0F0:  state_nx = S_IDLE;
            S_SKIP: begin
               if (skip_cnt <= 3'd1) begin
                  skip_nx  = 3'd0;
                  state_nx = S_IDLE;
               end else begin
                  skip_nx = skip_cnt - 3'd1;
               end
            end
            default: state_nx = S_IDLE;
         endcase
      end
   end

   // Prefix FSM outputs: a resolved key event for the current byte.
   always_comb begin
      evt_valid = 1'b0;
      evt_brk   = 1'b0;
      evt_ext   = 1'b0;
      if (code_valid) begin
         case (state)
            S_IDLE: begin
               case (code_in)
                  8'hE0, 8'hF0, 8'hE1,
                  8'hAA, 8'hFA, 8'hFE, 8'hEE: evt_valid = 1'b0;
                  default:                    evt_valid = 1'b1;
               endcase
            end
            S_E0: begin
               evt_valid = (code_in != 8'hF0);
               evt_ext   = 1'b1;
            end
            S_F0: begin
               evt_valid = 1'b1;
               evt_brk   = 1'b1;
            end
            S_E0F0: begin
               evt_valid = 1'b1;
               evt_brk   = 1'b1;
               evt_ext   = 1'b1;
            end
            default: evt_valid = 1'b0;
         endcase
      end
   end

   // Event classification: modifiers and fake shifts are consumed, not queued.
   always_comb begin
      is_shift  = !evt_ext && (code_in == 8'h12 || code_in == 8'h59);
      is_caps   = !evt_ext && (code_in == 8'h58);
      is_fake   = evt_ext && (code_in == 8'h12 || code_in == 8'h59);
      push      = evt_valid && !is_shift && !is_caps && !is_fake;
      evt_ascii = evt_ext ? 8'h00 : xlate(code_in, shift_held, caps_lock);
      evt_word  = {evt_ext, evt_brk, code_in, evt_ascii};
   end

   // Modifier tracking. The caps-held flag keeps typematic repeat from toggling.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         shift_l   <= 1'b0;
         shift_r   <= 1'b0;
         caps_held <= 1'b0;
         caps_lock <= 1'b0;
      end else if (evt_valid && !evt_ext) begin
         if (code_in == 8'h12) shift_l <= !evt_brk;
         if (code_in == 8'h59) shift_r <= !evt_brk;
         if (code_in == 8'h58) begin
            if (!evt_brk) begin
               if (!caps_held) caps_lock <= !caps_lock;
               caps_held <= 1'b1;
            end else begin
               caps_held <= 1'b0;
            end
         end
      end
   end

   assign shift_held = shift_l | shift_r;
   assign fsm_state  = state;

   // FIFO status. The extra pointer MSB separates full from empty.
   always_comb begin
      empty   = (wptr == rptr);
      full    = (wptr[ADDR_W] != rptr[ADDR_W]) &&
                (wptr[ADDR_W-1:0] == rptr[ADDR_W-1:0]);
      pop     = rd_en && !empty;
      push_ok = push && (!full || pop);
   end

   // FIFO storage. Stale contents are never visible because outputs are gated.
   always_ff @(posedge clk) begin
      if (push_ok) mem[wptr[ADDR_W-1:0]] <= evt_word;
   end

   // FIFO pointers and sticky overflow flag.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wptr     <= '0;
         rptr     <= '0;
         overflow <= 1'b0;
      end else begin
         if (push_ok) wptr <= wptr + (ADDR_W+1)'(1);
         if (pop)     rptr <= rptr + (ADDR_W+1)'(1);
         if (push && full && !pop) overflow <= 1'b1;
      end
   end

   // Head presentation. All fields read zero while the FIFO is empty.
   always_comb begin
      head      = mem[rptr[ADDR_W-1:0]];
      key_valid = !empty;
      fifo_full = full;
      key_ext   = key_valid ? head[17]    : 1'b0;
      key_break = key_valid ? head[16]    : 1'b0;
      key_code  = key_valid ? head[15:8]  : 8'h00;
      key_ascii = key_valid ? head[7:0]   : 8'h00;
   end

endmodule

// File: doc/ps2_key_decoder.md
# ps2_key_decoder

Downstream consumer of the PS/2 serial receiver. It takes completed 8-bit Set-2 scancode bytes, one per strobe. It resolves the multi-byte prefixes E0 (extended), F0 (break) and E1 (pause) and tracks the shift and caps-lock modifier state. Each resolved key event, carrying raw code, ASCII translation, make/break flag and extended flag, is pushed into a small first-word-fall-through FIFO. The CPU/VGA text side drains that FIFO with a read strobe.

## Interface
- FIFO_DEPTH, 8, event FIFO entries (power of two, ≥2)
- ADDR_W, 3, log2(FIFO_DEPTH)

- clk  in  1  system clock, all logic on posedge
- rst  in  1  asynchronous, active-high reset
- code_in  in  8  received scancode byte, valid only with code_valid
- code_valid  in  1  one-cycle strobe, at most one byte per cycle
- rd_en  in  1  pop head entry (ignored when key_valid=0)
- key_valid  out  1  FIFO not empty; head entry on key_* outputs
- key_ascii  out  8  ASCII of head entry, 0x00 if unmapped
- key_code  out  8  raw final scancode byte of head entry
- key_break  out  1  head entry is a release
- key_ext  out  1  head entry was E0-prefixed
- fifo_full  out  1  FIFO holds FIFO_DEPTH entries
- overflow  out  1  sticky, an event was dropped
- shift_held  out  1  left (0x12) or right (0x59) shift currently down
- caps_lock  out  1  caps-lock toggle state

## Operation
- Prefix FSM states: IDLE, E0, F0, E0F0, SKIP. Bytes are only consumed on code_valid.
- IDLE:
  - 0xE0 goes to E0.
  - 0xF0 goes to F0.
  - 0xE1 goes to SKIP with skip_cnt=7.
  - 0xAA, 0xFA, 0xFE, 0xEE are discarded and the FSM stays in IDLE.
  - Any other byte is a make event (brk=0, ext=0) and the FSM returns to IDLE.
- E0: 0xF0 goes to E0F0. Any other byte is a make event with ext=1, then IDLE.
- F0: any byte is a break event with ext=0, then IDLE.
- E0F0: any byte is a break event with ext=1, then IDLE.
- SKIP: each byte decrements skip_cnt. When skip_cnt reaches 0 the FSM returns to IDLE. The pause key produces no event.
- Event processing:
  - Non-extended 0x12 and 0x59 set or clear the left and right shift flags. They are not pushed.
  - Non-extended 0x58 make toggles caps_lock only if the caps key was not already held, so typematic repeat does not toggle. Break clears the held flag. It is not pushed.
  - Extended 0x12 and 0x59 (fake shifts) are discarded.
  - All other events are pushed: {ext, brk, code, ascii}.
- ASCII translation applies to non-extended codes only; extended codes give 0x00.
  - Letters 0x1C 'a' … 0x1A 'z' (full Set-2 letter map). The result is uppercase when shift_held XOR caps_lock.
  - Digit row 0x16 '1' … 0x45 '0'. Shift gives the US symbols !@#$%^&*(); caps_lock has no effect.
  - 0x29 gives 0x20, 0x5A gives 0x0D, 0x66 gives 0x08, 0x0D gives 0x09, 0x76 gives 0x1B.
  - Every other code gives 0x00.
- The modifier state used is the state before the current byte.
- FIFO: pointers are ADDR_W+1 bits wide and wrap modulo 2·FIFO_DEPTH. Full and empty are decided from the extra MSB.
  - Push while full and no pop in the same cycle: the entry is dropped and overflow is set.
  - Push and pop in the same cycle while full: both occur, no overflow.
  - Push and pop in the same cycle while empty: the push occurs and the pop is ignored.
- overflow clears only on rst.

## Timing
- Reset values:
  - FSM IDLE, skip_cnt 0, FIFO empty.
  - key_valid 0, fifo_full 0, overflow 0, shift_held 0, caps_lock 0.
  - key_ascii, key_code, key_break, key_ext all 0.
- Reset asserted mid-sequence (e.g. after E0 or F0) abandons the sequence. The next byte after release is interpreted from IDLE.
- Latency:
  - The event is written at the posedge that samples the final byte's code_valid.
  - key_valid and the key_* outputs reflect it in the following cycle (1-cycle latency).
- Modifier outputs update at the same edge that consumes the modifier byte.
- Pop: at the posedge where rd_en and key_valid are both 1, the head advances. The next entry, or key_valid=0, is visible in the following cycle.
- Back-to-back code_valid on consecutive cycles must be accepted without loss.

## Test plan
- 0x1C, then F0 1C → two entries: {ascii 0x61, code 0x1C, brk 0, ext 0} then {0x61, 0x1C, brk 1, ext 0}. key_valid rises the cycle after the first strobe.
- 12, 1C, F0 1C, F0 12 → entries 0x41 make and 0x41 break. shift_held is 1 between the 0x12 make and the 0x12 break. No shift entries are pushed.
- 58, 58, F0 58, then 16 → caps_lock=1 with a single toggle despite the repeat, then entry ascii 0x31. Follow with 12 16 → ascii 0x21.
- E0 75, E0 F0 75 → entries {code 0x75, ext 1, brk 0, ascii 0x00} and {ext 1, brk 1}. The sequence E1 14 77 E1 F0 14 F0 77 produces no entries and leaves the FSM in IDLE; a subsequent 0x29 gives ascii 0x20.
- Push 9 make events with FIFO_DEPTH=8 and no reads → fifo_full=1 after 8 events, overflow=1 after the 9th, 8 entries retained. With the FIFO full, a push and rd_en in the same cycle keeps it full and does not set overflow.
- Assert rst after E0 F0 arrives → all outputs return to reset values. Then 0x1C gives a make entry, not a break.
